// File: rtl/nova_io_intr_arb_pkg.sv
// Shared definitions for the Nova I/O interrupt arbiter: FSM state codes,
// well-known device codes and the CPU mask register width.
package nova_io_intr_arb_pkg;

    localparam int unsigned NOVA_MASK_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_HOLD   = 2'd2
    } arb_state_e;

    localparam logic [5:0] DEV_CPU = 6'o77;
    localparam logic [5:0] DEV_TTI = 6'o10;
    localparam logic [5:0] DEV_TTO = 6'o11;
    localparam logic [5:0] DEV_RTC = 6'o14;

endpackage

// File: rtl/nova_io_prio_enc.sv
// Combinational fixed-priority encoder: index of the lowest set bit of vec.
module nova_io_prio_enc #(
    parameter int unsigned NDEV = 8,
    localparam int unsigned IDX_W = (NDEV > 1) ? $clog2(NDEV) : 1
) (
    input  logic [NDEV-1:0]  vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        any = |vec;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/nova_io_intr_arb.sv
// Nova I/O bus interrupt arbiter: mask filtering, CPU request handshake FSM
// and INTA device-code responder.
module nova_io_intr_arb
    import nova_io_intr_arb_pkg::*;
#(
    parameter int unsigned       NDEV      = 8,
    parameter logic [6*NDEV-1:0] DEV_CODES = {8{6'o00}},
    parameter logic [4*NDEV-1:0] MASK_BITS = {8{4'd0}}
) (
    input  logic                   pclk,
    input  logic                   prst_n,
    input  logic                   bs_rst,
    input  logic [NDEV-1:0]        dev_irq,
    input  logic                   int_en,
    input  logic [0:NOVA_MASK_W-1] int_mask,
    output logic                   cntrl_intr,
    input  logic                   cntrl_intr_ack,
    input  logic                   inta_req,
    output logic                   inta_valid,
    output logic [5:0]             inta_code,
    output logic [NDEV-1:0]        pend_vec
);

    localparam int unsigned IDX_W = (NDEV > 1) ? $clog2(NDEV) : 1;

    arb_state_e       state_q, state_d;
    logic [NDEV-1:0]  pend_q;
    logic [NDEV-1:0]  eff;
    logic             inta_valid_q;
    logic [5:0]       inta_code_q;
    logic [5:0]       inta_code_d;
    logic             any_pend;
    logic [IDX_W-1:0] win_idx;

    // Mask bit numbering follows the Nova convention: int_mask[0] is the MSB.
    always_comb begin
        eff = '0;
        for (int i = 0; i < NDEV; i++) begin
            eff[i] = dev_irq[i] & ~int_mask[MASK_BITS[4*i +: 4]];
        end
    end

    nova_io_prio_enc #(
        .NDEV (NDEV)
    ) u_prio_enc (
        .vec (pend_q),
        .any (any_pend),
        .idx (win_idx)
    );

    always_comb begin
        inta_code_d = 6'o00;
        if (any_pend) begin
            inta_code_d = DEV_CODES[6*int'(win_idx) +: 6];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (int_en && any_pend) begin
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // Ack beats a simultaneous withdrawal so the CPU never sees a lost ack.
                if (cntrl_intr_ack) begin
                    state_d = ST_HOLD;
                end else if (!int_en || !any_pend) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Stay quiet until the CPU's ION clear has been seen.
                if (!int_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            inta_valid_q <= 1'b0;
            inta_code_q  <= 6'o00;
        end else if (bs_rst) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            inta_valid_q <= 1'b0;
            inta_code_q  <= 6'o00;
        end else begin
            state_q      <= state_d;
            pend_q       <= eff;
            inta_valid_q <= inta_req;
            if (inta_req) begin
                inta_code_q <= inta_code_d;
            end
        end
    end

    assign cntrl_intr = (state_q == ST_ASSERT);
    assign inta_valid = inta_valid_q;
    assign inta_code  = inta_code_q;
    assign pend_vec   = pend_q;

endmodule

// File: tb/tb_nova_io_intr_arb.sv
// Directed self-checking bench for nova_io_intr_arb.
module tb_nova_io_intr_arb;
    import nova_io_intr_arb_pkg::*;

    localparam int unsigned NDEV = 8;
    localparam logic [6*NDEV-1:0] CODES =
        {6'o00, 6'o00, 6'o00, 6'o00, DEV_CPU, DEV_RTC, DEV_TTO, DEV_TTI};
    localparam logic [4*NDEV-1:0] MBITS =
        {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd14, 4'd0};

    logic                   pclk;
    logic                   prst_n;
    logic                   bs_rst;
    logic [NDEV-1:0]        dev_irq;
    logic                   int_en;
    logic [0:NOVA_MASK_W-1] int_mask;
    logic                   cntrl_intr;
    logic                   cntrl_intr_ack;
    logic                   inta_req;
    logic                   inta_valid;
    logic [5:0]             inta_code;
    logic [NDEV-1:0]        pend_vec;

    int tests;
    int fails;

    nova_io_intr_arb #(
        .NDEV      (NDEV),
        .DEV_CODES (CODES),
        .MASK_BITS (MBITS)
    ) dut (
        .pclk           (pclk),
        .prst_n         (prst_n),
        .bs_rst         (bs_rst),
        .dev_irq        (dev_irq),
        .int_en         (int_en),
        .int_mask       (int_mask),
        .cntrl_intr     (cntrl_intr),
        .cntrl_intr_ack (cntrl_intr_ack),
        .inta_req       (inta_req),
        .inta_valid     (inta_valid),
        .inta_code      (inta_code),
        .pend_vec       (pend_vec)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        prst_n         = 1'b1;
        bs_rst         = 1'b0;
        dev_irq        = 8'hFF;
        int_en         = 1'b1;
        int_mask       = '0;
        cntrl_intr_ack = 1'b0;
        inta_req       = 1'b0;

        // Async reset with every device requesting and interrupts enabled
        #2 prst_n = 1'b0;
        tick();
        check("rst_intr", 32'(cntrl_intr), 32'd0);
        check("rst_code", 32'(inta_code), 32'd0);
        check("rst_pend", 32'(pend_vec), 32'd0);
        check("rst_valid", 32'(inta_valid), 32'd0);
        prst_n = 1'b1;
        tick();
        check("rel_pend", 32'(pend_vec), 32'hFF);
        check("rel_intr_n1", 32'(cntrl_intr), 32'd0);
        tick();
        check("rel_intr_n2", 32'(cntrl_intr), 32'd1);

        // I/O reset in ASSERT, with an INTA that must be ignored
        bs_rst   = 1'b1;
        inta_req = 1'b1;
        dev_irq  = '0;
        int_en   = 1'b0;
        tick();
        check("bsrst_intr", 32'(cntrl_intr), 32'd0);
        check("bsrst_pend", 32'(pend_vec), 32'd0);
        check("bsrst_valid", 32'(inta_valid), 32'd0);
        bs_rst   = 1'b0;
        inta_req = 1'b0;

        // Priority: devices 1 and 2 request, device 1 wins
        dev_irq = 8'b0000_0110;
        tick();
        check("prio_pend", 32'(pend_vec), 32'h06);
        inta_req = 1'b1;
        tick();
        check("prio_valid", 32'(inta_valid), 32'd1);
        check("prio_code", 32'(inta_code), 32'(6'o11));
        inta_req = 1'b0;
        tick();
        check("prio_valid_drop", 32'(inta_valid), 32'd0);
        check("prio_code_hold", 32'(inta_code), 32'(6'o11));
        dev_irq = 8'b1000_1000;
        tick();
        inta_req = 1'b1;
        tick();
        check("prio_code_cpu", 32'(inta_code), 32'(6'o77));
        inta_req = 1'b0;

        // Empty INTA
        dev_irq = '0;
        tick();
        inta_req = 1'b1;
        tick();
        check("empty_valid", 32'(inta_valid), 32'd1);
        check("empty_code", 32'(inta_code), 32'd0);
        inta_req = 1'b0;

        // Mask: device 1 mapped to mask bit 14
        int_en       = 1'b1;
        int_mask[14] = 1'b1;
        dev_irq      = 8'b0000_0010;
        tick();
        check("mask_pend", 32'(pend_vec), 32'd0);
        tick();
        check("mask_intr", 32'(cntrl_intr), 32'd0);
        int_mask[14] = 1'b0;
        tick();
        check("unmask_pend", 32'(pend_vec), 32'h02);
        check("unmask_intr_n1", 32'(cntrl_intr), 32'd0);
        tick();
        check("unmask_intr_n2", 32'(cntrl_intr), 32'd1);

        // Handshake: ack, HOLD while ION stays on, release via ION drop
        cntrl_intr_ack = 1'b1;
        tick();
        check("ack_intr", 32'(cntrl_intr), 32'd0);
        cntrl_intr_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_intr", 32'(cntrl_intr), 32'd0);
        end
        int_en = 1'b0;
        tick();
        check("hold_exit_intr", 32'(cntrl_intr), 32'd0);
        int_en = 1'b1;
        tick();
        check("refire_intr", 32'(cntrl_intr), 32'd1);

        // Withdrawal by request drop
        dev_irq = '0;
        tick();
        check("wd_intr_n1", 32'(cntrl_intr), 32'd1);
        tick();
        check("wd_intr_n2", 32'(cntrl_intr), 32'd0);

        // Race: ack together with ION drop must land in HOLD
        dev_irq = 8'b0000_0010;
        tick();
        tick();
        check("race_assert", 32'(cntrl_intr), 32'd1);
        cntrl_intr_ack = 1'b1;
        int_en         = 1'b0;
        tick();
        check("race_intr", 32'(cntrl_intr), 32'd0);
        cntrl_intr_ack = 1'b0;
        int_en         = 1'b1;
        tick();
        check("race_hold1", 32'(cntrl_intr), 32'd0);
        tick();
        check("race_hold2", 32'(cntrl_intr), 32'd0);

        // Withdrawal by ION drop goes to IDLE, not HOLD
        int_en = 1'b0;
        tick();
        int_en = 1'b1;
        tick();
        check("en_assert", 32'(cntrl_intr), 32'd1);
        int_en = 1'b0;
        tick();
        check("en_wd_intr", 32'(cntrl_intr), 32'd0);
        int_en = 1'b1;
        tick();
        check("en_refire", 32'(cntrl_intr), 32'd1);

        // Async reset mid-flight clears immediately
        prst_n = 1'b0;
        #1;
        check("async_intr", 32'(cntrl_intr), 32'd0);
        check("async_pend", 32'(pend_vec), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
